// File: rtl/mem_sram_controller_if.sv
// Pipeline-side handshake bundle for mem_sram_controller.
// The MEM stage is the master; the controller is the slave.
interface mem_sram_controller_if #(
  parameter int unsigned LEN = 32
);
  logic           wr_en;
  logic           rd_en;
  logic [LEN-1:0] address;
  logic [LEN-1:0] write_data;
  logic [LEN-1:0] read_data;
  logic           ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/mem_sram_controller.sv
// Multi-cycle data-memory controller: each 32-bit load/store becomes two
// 16-bit asynchronous SRAM accesses; ready stays low to freeze the pipeline.
module mem_sram_controller #(
  parameter int unsigned LEN         = 32,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_sram_controller_if.slave  bus,
  output logic [17:0]           sram_addr,
  output logic [15:0]           sram_dq_out,
  input  logic [15:0]           sram_dq_in,
  output logic                  sram_dq_oe,
  output logic                  sram_we_n,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [16:0]    word_q, word_d;
  logic [LEN-1:0] wdata_q, wdata_d;
  logic           is_wr_q, is_wr_d;
  logic [15:0]    low_q, low_d;
  logic [LEN-1:0] rdata_q, rdata_d;

  logic [LEN-1:0] offset;
  logic [16:0]    word_in;
  logic           last_cycle;
  logic           ready_c;

  // Out-of-range addresses simply wrap into the 17-bit word space.
  assign offset     = bus.address - LEN'(BASE_ADDR);
  assign word_in    = 17'(offset >> 2);
  assign last_cycle = (cnt_q == 4'(WAIT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      low_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      low_q   <= low_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    is_wr_d     = is_wr_q;
    low_d       = low_q;
    rdata_d     = rdata_q;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    ready_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_c = ~bus.wr_en & ~bus.rd_en;
        if (bus.wr_en || bus.rd_en) begin
          word_d  = word_in;
          wdata_d = bus.write_data;
          is_wr_d = bus.wr_en;
          cnt_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        sram_addr = {word_q, 1'b0};
        if (is_wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = S_HIGH;
          if (!is_wr_q) low_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (is_wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (last_cycle) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!is_wr_q) rdata_d = LEN'({sram_dq_in, low_q});
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ready_c = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready     = ready_c;
  assign bus.read_data = rdata_q;

  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench for mem_sram_controller with W=2 (main), W=1 and W=15 instances,
// each attached to a small behavioural asynchronous SRAM array.
module tb_mem_sram_controller;

  logic clock = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  mem_sram_controller_if #(.LEN(32)) bus2 ();
  mem_sram_controller_if #(.LEN(32)) bus1 ();
  mem_sram_controller_if #(.LEN(32)) bus15 ();

  logic [17:0] a2, a1, a15;
  logic [15:0] dqo2, dqo1, dqo15;
  logic [15:0] dqi2, dqi1, dqi15;
  logic        oe2, oe1, oe15;
  logic        we2, we1, we15;
  logic [3:0]  ctl2, ctl1, ctl15;

  logic [15:0] mem2  [256];
  logic [15:0] mem1  [256];
  logic [15:0] mem15 [256];
  int          wcnt2 [256];
  logic [17:0] last_wa;

  assign dqi2  = mem2[a2[7:0]];
  assign dqi1  = mem1[a1[7:0]];
  assign dqi15 = mem15[a15[7:0]];

  mem_sram_controller #(.LEN(32), .BASE_ADDR(1024), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2),
    .sram_addr(a2), .sram_dq_out(dqo2), .sram_dq_in(dqi2), .sram_dq_oe(oe2),
    .sram_we_n(we2), .sram_ce_n(ctl2[0]), .sram_oe_n(ctl2[1]),
    .sram_ub_n(ctl2[2]), .sram_lb_n(ctl2[3])
  );

  mem_sram_controller #(.LEN(32), .BASE_ADDR(1024), .WAIT_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .sram_addr(a1), .sram_dq_out(dqo1), .sram_dq_in(dqi1), .sram_dq_oe(oe1),
    .sram_we_n(we1), .sram_ce_n(ctl1[0]), .sram_oe_n(ctl1[1]),
    .sram_ub_n(ctl1[2]), .sram_lb_n(ctl1[3])
  );

  mem_sram_controller #(.LEN(32), .BASE_ADDR(1024), .WAIT_CYCLES(15)) dut15 (
    .clock(clock), .reset(reset), .bus(bus15),
    .sram_addr(a15), .sram_dq_out(dqo15), .sram_dq_in(dqi15), .sram_dq_oe(oe15),
    .sram_we_n(we15), .sram_ce_n(ctl15[0]), .sram_oe_n(ctl15[1]),
    .sram_ub_n(ctl15[2]), .sram_lb_n(ctl15[3])
  );

  // SRAM write port of the main instance; also tallies write-strobe cycles per half-word.
  always @(posedge clock) begin
    if (!we2) begin
      mem2[a2[7:0]]  = dqo2;
      wcnt2[a2[7:0]] = wcnt2[a2[7:0]] + 1;
      last_wa        = a2;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int which, input logic wr, input logic rd,
                         input logic [31:0] a, input logic [31:0] d);
    if (which == 1) begin
      bus1.wr_en = wr; bus1.rd_en = rd; bus1.address = a; bus1.write_data = d;
    end else if (which == 15) begin
      bus15.wr_en = wr; bus15.rd_en = rd; bus15.address = a; bus15.write_data = d;
    end else begin
      bus2.wr_en = wr; bus2.rd_en = rd; bus2.address = a; bus2.write_data = d;
    end
  endtask

  function automatic logic get_ready(input int which);
    if (which == 1) return bus1.ready;
    if (which == 15) return bus15.ready;
    return bus2.ready;
  endfunction

  function automatic logic [31:0] get_rdata(input int which);
    if (which == 1) return bus1.read_data;
    if (which == 15) return bus15.read_data;
    return bus2.read_data;
  endfunction

  // Issues one request, counts ready-low cycles, returns read_data seen in DONE.
  task automatic access(input int which, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lowcnt, output logic [31:0] rdata, output logic timeout);
    @(negedge clock);
    set_req(which, wr, rd, a, d);
    lowcnt  = 0;
    timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (get_ready(which)) begin
        timeout = 1'b0;
        break;
      end
      lowcnt++;
      @(negedge clock);
    end
    rdata = get_rdata(which);
    set_req(which, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lc;
    int          gap;
    logic [31:0] rd;
    logic        to;

    for (int i = 0; i < 256; i++) begin
      mem2[i] = '0; mem1[i] = '0; mem15[i] = '0; wcnt2[i] = 0;
    end
    last_wa = '0;
    set_req(2, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(15, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;

    repeat (3) @(negedge clock);
    #1;
    check("rst_ready", 64'(bus2.ready), 64'h1);
    check("rst_read_data", 64'(bus2.read_data), 64'h0);
    check("rst_sram_addr", 64'(a2), 64'h0);
    check("rst_dq_out_oe_we", 64'({dqo2, oe2, we2}), 64'h1);
    check("rst_ctl_pins", 64'(ctl2), 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      check("idle_ready_we_oe", 64'({bus2.ready, we2, oe2}), 64'b110);
    end

    access(2, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lc, rd, to);
    check("st_timeout", 64'(to), 64'h0);
    check("st_ready_low", 64'(lc), 64'd5);
    check("st_hw2", 64'(mem2[2]), 64'hBEEF);
    check("st_hw3", 64'(mem2[3]), 64'hDEAD);
    check("st_we_cycles_hw2", 64'(wcnt2[2]), 64'd2);
    check("st_we_cycles_hw3", 64'(wcnt2[3]), 64'd2);
    check("st_read_data_kept", 64'(rd), 64'h0);

    access(2, 1'b0, 1'b1, 32'd1028, 32'h0, lc, rd, to);
    check("ld_timeout", 64'(to), 64'h0);
    check("ld_ready_low", 64'(lc), 64'd5);
    check("ld_data", 64'(rd), 64'hDEADBEEF);

    mem2[0] = 16'h2222; mem2[1] = 16'h1111;
    mem2[4] = 16'h4444; mem2[5] = 16'h3333;
    @(negedge clock);
    bus2.rd_en = 1'b1; bus2.address = 32'd1024;
    lc = 0; to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus2.ready) begin to = 1'b0; break; end
      lc++;
      @(negedge clock);
    end
    check("b2b_first_timeout", 64'(to), 64'h0);
    check("b2b_first_ready_low", 64'(lc), 64'd5);
    check("b2b_first_data", 64'(bus2.read_data), 64'h11112222);
    bus2.address = 32'd1032;
    gap = 0; to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      #1;
      gap++;
      if (bus2.ready) begin to = 1'b0; break; end
    end
    check("b2b_second_timeout", 64'(to), 64'h0);
    check("b2b_ready_spacing", 64'(gap), 64'd6);
    check("b2b_second_data", 64'(bus2.read_data), 64'h33334444);
    bus2.rd_en = 1'b0;

    access(2, 1'b1, 1'b1, 32'd1024, 32'h0000A5A5, lc, rd, to);
    check("both_ready_low", 64'(lc), 64'd5);
    check("both_hw0", 64'(mem2[0]), 64'hA5A5);
    check("both_hw1", 64'(mem2[1]), 64'h0000);
    check("both_read_data_kept", 64'(rd), 64'h33334444);

    access(2, 1'b1, 1'b0, 32'd1020, 32'h12345678, lc, rd, to);
    check("wrap_hw_lo", 64'(mem2[8'hFE]), 64'h5678);
    check("wrap_hw_hi", 64'(mem2[8'hFF]), 64'h1234);
    check("wrap_last_addr", 64'(last_wa), 64'h3FFFF);

    @(negedge clock);
    bus2.rd_en = 1'b1; bus2.address = 32'd1028;
    repeat (3) @(negedge clock);
    #1;
    check("mid_high_addr", 64'(a2), 64'h3);
    reset = 1'b0;
    #1;
    check("rstmid_read_data", 64'(bus2.read_data), 64'h0);
    check("rstmid_we_oe_addr", 64'({we2, oe2, a2}), 64'({1'b1, 1'b0, 18'h0}));
    bus2.rd_en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("rstmid_idle_ready", 64'(bus2.ready), 64'h1);
    check("rstmid_no_partial", 64'(bus2.read_data), 64'h0);
    access(2, 1'b0, 1'b1, 32'd1028, 32'h0, lc, rd, to);
    check("reissue_ready_low", 64'(lc), 64'd5);
    check("reissue_data", 64'(rd), 64'hDEADBEEF);

    mem1[16]  = 16'hCDEF; mem1[17]  = 16'h89AB;
    mem15[16] = 16'h2D3C; mem15[17] = 16'h0F1E;
    access(1, 1'b0, 1'b1, 32'd1056, 32'h0, lc, rd, to);
    check("w1_timeout", 64'(to), 64'h0);
    check("w1_ready_low", 64'(lc), 64'd3);
    check("w1_data", 64'(rd), 64'h89ABCDEF);
    access(15, 1'b0, 1'b1, 32'd1056, 32'h0, lc, rd, to);
    check("w15_timeout", 64'(to), 64'h0);
    check("w15_ready_low", 64'(lc), 64'd31);
    check("w15_data", 64'(rd), 64'h0F1E2D3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
